// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the 8259-style PIC host sequencer.
//   - seq_state_t : sequencer states
//   - OCW2_NS_EOI : operation command word for a non-specific end of interrupt
//   - ICW1_IC4 / ICW1_SNGL : bit positions inside ICW1
//   - WI_*        : position codes of the init words in the write list
package pic_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    W_SETUP  = 4'd1,
    W_STROBE = 4'd2,
    W_HOLD   = 4'd3,
    READY    = 4'd4,
    ACK1     = 4'd5,
    ACK_GAP  = 4'd6,
    ACK2     = 4'd7,
    ACK_DONE = 4'd8
  } seq_state_t;

  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;

  // Init write list positions, in bus order.
  localparam logic [2:0] WI_ICW1 = 3'd0;
  localparam logic [2:0] WI_ICW2 = 3'd1;
  localparam logic [2:0] WI_ICW3 = 3'd2;
  localparam logic [2:0] WI_ICW4 = 3'd3;
  localparam logic [2:0] WI_OCW1 = 3'd4;

endpackage

// File: rtl/pic_strobe_timer.sv
// pic_strobe_timer: loadable down-counter that times strobe and gap phases.
//   clk        in  : system clock
//   reset      in  : asynchronous active-high reset
//   load       in  : load load_value (the first cycle of a new phase follows)
//   load_value in  : phase length minus one
//   done       out : registered; high during the last cycle of the loaded phase
module pic_strobe_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Count down from the loaded value; done is asserted for the final count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      done    <= 1'b1;
    end else if (load) begin
      count_r <= load_value;
      done    <= (load_value == '0);
    end else if (count_r != '0) begin
      count_r <= count_r - WIDTH'(1);
      done    <= (count_r == WIDTH'(1));
    end else begin
      count_r <= count_r;
      done    <= 1'b1;
    end
  end

endmodule

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: CPU-side bus master for the 8259-style interrupt
// controller. Programs ICW1..ICW4 and OCW1 after start, then serves INT with a
// two-pulse INTA acknowledge (vector read on the second pulse) and writes a
// non-specific EOI when eoi_req is raised. eoi_req wins over INT in READY.
//   clk, reset      : system clock, asynchronous active-high reset
//   start           : begin initialisation (only honoured in IDLE)
//   eoi_req         : level request for a non-specific EOI, held until eoi_ack
//   INT             : interrupt request from the controller
//   DATA_IN         : data bus as seen by this block
//   DATA_OUT/DATA_OE: value and enable for the wrapper's tristate driver
//   CS, A0, WR, RD, INTA : controller bus controls (CS/WR/RD/INTA active-low)
//   init_done       : set after the OCW1 write, cleared only by reset
//   vector          : last acknowledged interrupt vector
//   vector_valid    : one-cycle pulse when vector updates
//   eoi_ack         : one-cycle pulse in the hold cycle of the EOI write
//   busy            : high in every state except IDLE and READY
// All outputs are registered and follow the state they belong to.
module pic_host_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] ICW1         = 8'h13,
  parameter logic [7:0] ICW2         = 8'h08,
  parameter logic [7:0] ICW3         = 8'h00,
  parameter logic [7:0] ICW4         = 8'h01,
  parameter logic [7:0] OCW1         = 8'h00,
  parameter int         PULSE_CYCLES = 2,
  parameter int         GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       eoi_req,
  input  logic       INT,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       CS,
  output logic       A0,
  output logic       WR,
  output logic       RD,
  output logic       INTA,
  output logic       init_done,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       eoi_ack,
  output logic       busy
);

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  seq_state_t     state_r;
  seq_state_t     next_s;
  logic [2:0]     widx_r;      // position of the current init word
  logic           eoi_mode_r;  // current write cycle is the EOI, not init
  logic           tmr_load_s;
  logic [TW-1:0]  tmr_value_s;
  logic           tmr_done_s;

  // Next write list position, skipping ICW3 in single mode and ICW4 without IC4.
  function automatic logic [2:0] next_widx(input logic [2:0] cur);
    logic [2:0] n;
    n = cur + 3'd1;
    if ((n == WI_ICW3) && ICW1[ICW1_SNGL]) n = WI_ICW4;
    else n = n;
    if ((n == WI_ICW4) && !ICW1[ICW1_IC4]) n = WI_OCW1;
    else n = n;
    return n;
  endfunction

  function automatic logic [7:0] init_word(input logic [2:0] idx);
    case (idx)
      WI_ICW1: init_word = ICW1;
      WI_ICW2: init_word = ICW2;
      WI_ICW3: init_word = ICW3;
      WI_ICW4: init_word = ICW4;
      default: init_word = OCW1;
    endcase
  endfunction

  // Timer reload for a state: its length in clocks minus one.
  function automatic logic [TW-1:0] phase_count(input seq_state_t s);
    case (s)
      W_STROBE, ACK1, ACK2: phase_count = TW'(PULSE_CYCLES - 1);
      ACK_GAP:              phase_count = TW'(GAP_CYCLES - 1);
      default:              phase_count = '0;
    endcase
  endfunction

  pic_strobe_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load_s),
    .load_value (tmr_value_s),
    .done       (tmr_done_s)
  );

  // Next-state decision; every timed state waits for the timer's last cycle.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:     if (start) next_s = W_SETUP; else next_s = IDLE;
      W_SETUP:  if (tmr_done_s) next_s = W_STROBE; else next_s = W_SETUP;
      W_STROBE: if (tmr_done_s) next_s = W_HOLD; else next_s = W_STROBE;
      W_HOLD: begin
        if (!tmr_done_s) next_s = W_HOLD;
        else if (eoi_mode_r || (widx_r == WI_OCW1)) next_s = READY;
        else next_s = W_SETUP;
      end
      READY: begin
        if (!init_done) next_s = READY;
        else if (eoi_req) next_s = W_SETUP;
        else if (INT) next_s = ACK1;
        else next_s = READY;
      end
      ACK1:     if (tmr_done_s) next_s = ACK_GAP; else next_s = ACK1;
      ACK_GAP:  if (tmr_done_s) next_s = ACK2; else next_s = ACK_GAP;
      ACK2:     if (tmr_done_s) next_s = ACK_DONE; else next_s = ACK2;
      ACK_DONE: next_s = READY;
      default:  next_s = IDLE;
    endcase
  end

  // The timer is reloaded on every state change, so each phase starts fresh.
  always_comb begin
    tmr_load_s  = (next_s != state_r);
    tmr_value_s = phase_count(next_s);
  end

  // State register and registered bus outputs, decoded from the state entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      widx_r       <= WI_ICW1;
      eoi_mode_r   <= 1'b0;
      DATA_OUT     <= 8'h00;
      DATA_OE      <= 1'b0;
      CS           <= 1'b1;
      A0           <= 1'b0;
      WR           <= 1'b1;
      RD           <= 1'b1;
      INTA         <= 1'b1;
      init_done    <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      eoi_ack      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r <= next_s;
      CS      <= (next_s == IDLE) || (next_s == READY) || (next_s == ACK_DONE);
      WR      <= (next_s != W_STROBE);
      RD      <= (next_s != ACK2);
      INTA    <= !((next_s == ACK1) || (next_s == ACK2));
      DATA_OE <= (next_s == W_SETUP) || (next_s == W_STROBE) || (next_s == W_HOLD);
      busy    <= !((next_s == IDLE) || (next_s == READY));

      eoi_ack      <= eoi_mode_r && (next_s == W_HOLD) && (state_r == W_STROBE);
      vector_valid <= (state_r == ACK2) && (next_s == ACK_DONE);

      // The vector is taken on the last cycle of the second INTA pulse.
      if ((state_r == ACK2) && (next_s == ACK_DONE)) vector <= DATA_IN;
      else vector <= vector;

      if ((state_r == W_HOLD) && (next_s == READY) && !eoi_mode_r) init_done <= 1'b1;
      else init_done <= init_done;

      // Present the address and data of the next write on entering W_SETUP.
      if ((next_s == W_SETUP) && (state_r != W_SETUP)) begin
        case (state_r)
          IDLE: begin
            widx_r     <= WI_ICW1;
            eoi_mode_r <= 1'b0;
            DATA_OUT   <= ICW1;
            A0         <= 1'b0;
          end
          READY: begin
            widx_r     <= widx_r;
            eoi_mode_r <= 1'b1;
            DATA_OUT   <= OCW2_NS_EOI;
            A0         <= 1'b0;
          end
          default: begin
            widx_r     <= next_widx(widx_r);
            eoi_mode_r <= eoi_mode_r;
            DATA_OUT   <= init_word(next_widx(widx_r));
            A0         <= 1'b1;
          end
        endcase
      end else begin
        widx_r     <= widx_r;
        eoi_mode_r <= eoi_mode_r;
        DATA_OUT   <= DATA_OUT;
        A0         <= A0;
      end
    end
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Bench for pic_host_sequencer: a default-parameter instance carries the main
// tests; a cascade instance (ICW1=8'h11) shares clock/reset/start to check the
// five-word init list. Bus writes and vectors are scoreboarded via queues.
module tb_pic_host_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, eoi_req, int_req;
  logic [7:0] resp_vec;
  logic [7:0] data_in, data_out, vector;
  logic       data_oe, cs, a0, wr, rd, inta, init_done, vector_valid, eoi_ack, busy;

  logic       eoi2 = 1'b0, int2 = 1'b0;
  logic [7:0] data_in2 = 8'hFF;
  logic [7:0] data_out2, vector2;
  logic       data_oe2, cs2, a0_2, wr2, rd2, inta2, init_done2, vector_valid2, eoi_ack2, busy2;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  logic [8:0] exp_wq[$];   // expected {A0, data} per bus write
  logic [7:0] exp_vq[$];   // expected captured vectors
  logic [8:0] got2[$];     // writes seen on the cascade instance

  typedef struct {
    logic       eoi;
    logic       intr;
    logic [7:0] resp;
    int         eoi_n;   // cycle after request when eoi_ack is seen
    int         vv_n;    // cycle after request when vector_valid is seen
  } vec_t;
  vec_t tbl[5];

  logic [8:0] exp2[5];

  logic wr_prev = 1'b1, wr2_prev = 1'b1;
  int   eoi_n, vv_n, n1, n2, saved_wr;
  logic [6:0] inta_h, rd_h;

  always #5 clk = ~clk;

  // Controller model: returns resp_vec while RD and INTA are both low.
  assign data_in = (!rd && !inta) ? resp_vec : 8'hFF;

  pic_host_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .eoi_req(eoi_req), .INT(int_req),
    .DATA_IN(data_in), .DATA_OUT(data_out), .DATA_OE(data_oe), .CS(cs), .A0(a0),
    .WR(wr), .RD(rd), .INTA(inta), .init_done(init_done), .vector(vector),
    .vector_valid(vector_valid), .eoi_ack(eoi_ack), .busy(busy)
  );

  pic_host_sequencer #(.ICW1(8'h11)) dut2 (
    .clk(clk), .reset(reset), .start(start), .eoi_req(eoi2), .INT(int2),
    .DATA_IN(data_in2), .DATA_OUT(data_out2), .DATA_OE(data_oe2), .CS(cs2), .A0(a0_2),
    .WR(wr2), .RD(rd2), .INTA(inta2), .init_done(init_done2), .vector(vector2),
    .vector_valid(vector_valid2), .eoi_ack(eoi_ack2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: each WR falling edge pops one expected {A0, data}.
  always @(negedge clk) begin
    if (reset) begin
      wr_prev = 1'b1;
    end else begin
      if (!wr && wr_prev) begin
        wr_count++;
        if (exp_wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got a0=%0b data=0x%0h with no write expected", a0, data_out);
        end else begin
          check("write_a0_data", {a0, data_out}, exp_wq.pop_front());
          check("write_cs_oe", {cs, data_oe}, 2'b01);
        end
      end
      wr_prev = wr;
    end
  end

  // Vector monitor: each vector_valid pulse pops one expected vector.
  always @(negedge clk) begin
    if (!reset && vector_valid) begin
      if (exp_vq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got 0x%0h with no vector expected", vector);
      end else begin
        check("vector", vector, exp_vq.pop_front());
      end
    end
  end

  // Cascade instance write recorder.
  always @(negedge clk) begin
    if (reset) begin
      wr2_prev = 1'b1;
    end else begin
      if (!wr2 && wr2_prev) got2.push_back({a0_2, data_out2});
      wr2_prev = wr2;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {eoi, int, response, eoi_ack cycle, vector_valid cycle}
    tbl[0] = '{1'b0, 1'b1, 8'h0B, 0, 7};
    tbl[1] = '{1'b0, 1'b1, 8'h0A, 0, 7};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 4, 0};
    tbl[3] = '{1'b1, 1'b1, 8'h0C, 4, 12};
    tbl[4] = '{1'b0, 1'b1, 8'hF5, 0, 7};
    exp2[0] = 9'h011; exp2[1] = 9'h108; exp2[2] = 9'h100; exp2[3] = 9'h101; exp2[4] = 9'h100;

    reset = 1'b1; start = 1'b0; eoi_req = 1'b0; int_req = 1'b0; resp_vec = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_strobes", {cs, wr, rd, inta, a0, data_oe}, 6'b111100);
    check("reset_data", {data_out, vector}, 16'h0000);
    check("reset_flags", {init_done, vector_valid, eoi_ack, busy}, 4'b0000);
    check("reset2", {cs2, wr2, rd2, inta2, data_oe2, init_done2, vector_valid2, eoi_ack2, busy2, vector2},
          {9'b111100000, 8'h00});
    reset = 1'b0;

    // INT and eoi_req before init do nothing.
    @(negedge clk); int_req = 1'b1; eoi_req = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("ignore_before_init", {busy, inta, wr, cs}, 4'b0111);
    int_req = 1'b0; eoi_req = 1'b0;

    // Reset asserted in the middle of the first WR strobe.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 check("strobe_low", {wr, cs, data_oe, busy}, 4'b0011);
    reset = 1'b1;
    #1 check("async_reset", {wr, cs, data_oe, init_done, busy, inta, rd}, 7'b1100011);
    @(negedge clk); reset = 1'b0;

    // Full default init; cascade instance runs its five-word list alongside.
    got2.delete();
    wr_count = 0;
    exp_wq.push_back(9'h013); exp_wq.push_back(9'h108);
    exp_wq.push_back(9'h101); exp_wq.push_back(9'h100);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n1 = 0; n2 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (init_done && n1 == 0) n1 = n;
      if (init_done2 && n2 == 0) n2 = n;
      if (n1 != 0 && n2 != 0) break;
    end
    check("init_latency", n1, 16);
    check("init_latency_cascade", n2, 20);
    check("init_write_count", wr_count, 4);
    check("init_writes_left", exp_wq.size(), 0);
    check("ready_bus_idle", {cs, data_oe, wr, busy}, 4'b1010);
    check("cascade_write_count", got2.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < got2.size()) check("cascade_write", got2[k], exp2[k]);
    end

    // start in READY is ignored.
    saved_wr = wr_count;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("start_ignored", {busy, init_done, 24'(wr_count)}, {1'b0, 1'b1, 24'(saved_wr)});

    // Table of EOI / INTA scenarios.
    for (int i = 0; i < 5; i++) begin
      eoi_n = 0; vv_n = 0; inta_h = '1; rd_h = '1;
      if (tbl[i].eoi) exp_wq.push_back(9'h020);
      if (tbl[i].intr) exp_vq.push_back(tbl[i].resp);
      @(negedge clk);
      resp_vec = tbl[i].resp; eoi_req = tbl[i].eoi; int_req = tbl[i].intr;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        inta_h = {inta_h[5:0], inta};
        rd_h   = {rd_h[5:0], rd};
        if (eoi_ack && eoi_n == 0) begin
          eoi_n = n;
          eoi_req = 1'b0;
        end
        if (vector_valid && vv_n == 0) begin
          vv_n = n;
          int_req = 1'b0;
          check("inta_rd_shape", {inta_h, rd_h}, {7'b0011001, 7'b1111001});
        end
        if ((!tbl[i].eoi || eoi_n != 0) && (!tbl[i].intr || vv_n != 0)) break;
      end
      eoi_req = 1'b0; int_req = 1'b0;
      if (tbl[i].eoi) check("eoi_ack_cycle", eoi_n, tbl[i].eoi_n);
      if (tbl[i].intr) check("vector_valid_cycle", vv_n, tbl[i].vv_n);
      @(posedge clk); #1;
      check("back_to_ready", {vector_valid, eoi_ack, busy, cs, data_oe}, 5'b00010);
    end
    check("eoi_writes_left", exp_wq.size(), 0);

    // INT dropped during ACK_GAP: cycle completes, spurious vector captured.
    exp_vq.push_back(8'h0F);
    @(negedge clk); resp_vec = 8'h0F; int_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("in_ack_gap", {inta, cs, busy}, 3'b101);
    int_req = 1'b0;
    vv_n = 0;
    for (int n = 4; n <= 40; n++) begin
      @(posedge clk); #1;
      if (vector_valid) begin
        vv_n = n;
        break;
      end
    end
    check("spurious_vv_cycle", vv_n, 7);
    check("spurious_vector", vector, 8'h0F);
    @(posedge clk); #1;
    check("after_spurious", {busy, inta, vector_valid}, 3'b010);
    check("vectors_left", exp_vq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
